// File: rtl/hit_score_counter.sv
// Game-phase FSM and score/combo tracker feeding the two-digit display controller.
// Judgement pulses are applied only while playing, with saturation at MAX_SCORE.
module hit_score_counter #(
  parameter int MAX_SCORE   = 99,
  parameter int PERFECT_PTS = 2,
  parameter int GOOD_PTS    = 1,
  parameter int COMBO_BONUS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       song_end,
  input  logic       hit_perfect,
  input  logic       hit_good,
  input  logic       hit_miss,
  input  logic [1:0] disp_sel,
  output logic [7:0] amt,
  output logic [6:0] score,
  output logic [6:0] combo,
  output logic [6:0] max_combo,
  output logic [1:0] state,
  output logic       game_over
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] MAX7      = 7'(MAX_SCORE);
  localparam logic [7:0] PERFECT8  = 8'(PERFECT_PTS);
  localparam logic [7:0] GOOD8     = 8'(GOOD_PTS);
  localparam int         BONUS_DIV = (COMBO_BONUS == 0) ? 1 : COMBO_BONUS;

  logic [1:0] state_q, state_d;
  logic [6:0] score_q, score_d;
  logic [6:0] combo_q, combo_d;
  logic [6:0] max_q, max_d;

  // 8-bit sum before clamping so a near-ceiling score never wraps.
  function automatic logic [6:0] sat_add(input logic [6:0] base, input logic [7:0] inc);
    logic [7:0] sum;
    sum = {1'b0, base} + inc;
    return (sum > {1'b0, MAX7}) ? MAX7 : sum[6:0];
  endfunction

  function automatic logic bonus_due(input logic [6:0] cur, input logic [6:0] nxt);
    if (COMBO_BONUS == 0) return 1'b0;
    return (nxt != cur) && ((int'(nxt) % BONUS_DIV) == 0);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      score_q <= '0;
      combo_q <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      combo_q <= combo_d;
      max_q   <= max_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)    state_d = S_PLAY;
      S_PLAY:  if (song_end) state_d = S_DONE;
      S_DONE:  if (start)    state_d = S_PLAY;
      default:               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    logic [7:0] inc;
    inc     = '0;
    score_d = score_q;
    combo_d = combo_q;
    max_d   = max_q;
    if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      score_d = '0;
      combo_d = '0;
      max_d   = '0;
    end else if (state_q == S_PLAY) begin
      // Priority perfect > good > miss; only one judgement lands per cycle.
      if (hit_perfect || hit_good) begin
        combo_d = (combo_q >= MAX7) ? MAX7 : 7'(combo_q + 7'd1);
        inc     = (hit_perfect ? PERFECT8 : GOOD8) + {7'd0, bonus_due(combo_q, combo_d)};
        score_d = sat_add(score_q, inc);
      end else if (hit_miss) begin
        combo_d = '0;
      end
      if (combo_d > max_q) max_d = combo_d;
    end
  end

  always_comb begin
    game_over = (state_q == S_DONE);
    case (disp_sel)
      2'd1:    amt = {1'b0, combo_q};
      2'd2:    amt = {1'b0, max_q};
      default: amt = {1'b0, score_q};
    endcase
  end

  assign score     = score_q;
  assign combo     = combo_q;
  assign max_combo = max_q;
  assign state     = state_q;

endmodule

// File: doc/hit_score_counter.md
Name: hit_score_counter

Overview:
Upstream of the 7-segment/VGA digit controller. Consumes single-cycle note-judgement pulses from the note judge and tracks game state, a saturating score, the current combo and the maximum combo. Produces the 8-bit `amt` value (always < 100) that the digit controller renders as two decimal digits. Owns the game-phase FSM (idle, playing, done).

Parameters:
MAX_SCORE, 99, saturation ceiling for score and combo counters; must be <= 99.
PERFECT_PTS, 2, points added for a perfect hit.
GOOD_PTS, 1, points added for a good hit.
COMBO_BONUS, 10, combo multiple that awards 1 extra point; 0 disables the bonus.

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high
start  in  1  single-cycle pulse; begins or restarts a game from IDLE or DONE
song_end  in  1  single-cycle pulse; end of chart
hit_perfect  in  1  single-cycle judgement pulse
hit_good  in  1  single-cycle judgement pulse
hit_miss  in  1  single-cycle judgement pulse
disp_sel  in  2  display source: 0 = score, 1 = combo, 2 = max_combo, 3 = score
amt  out  8  value for the digit controller; bit 7 is always 0
score  out  7  current score
combo  out  7  current combo
max_combo  out  7  best combo this game
state  out  2  0 = IDLE, 1 = PLAY, 2 = DONE
game_over  out  1  high while in DONE

Behaviour:
- Clock and reset: reset is synchronous, active-high; the clock is clk. Reset forces state = IDLE and sets score, combo and max_combo to 0. Therefore amt = 0 and game_over = 0.
- All counters and state are registers. `amt` is a combinational mux of registered values, so it has zero added latency.
- Latency: a pulse sampled at edge N is reflected on the outputs after edge N.

FSM:
- IDLE --start--> PLAY. The same edge clears score, combo and max_combo.
- PLAY --song_end--> DONE.
- DONE --start--> PLAY, clearing score, combo and max_combo as above.
- Encoding 3 is illegal and recovers to IDLE on the next edge.
- start while in PLAY is ignored; there is no mid-game restart.
- In IDLE and DONE, judgement pulses are ignored and the counters hold their values.

Judgement rules (PLAY only):
- Pulses are arbitrated by priority: perfect > good > miss. Only one judgement is applied per cycle; lower-priority pulses in the same cycle are dropped.
- Perfect or good:
  - combo_next = min(combo + 1, MAX_SCORE).
  - score_next = min(score + pts + bonus, MAX_SCORE).
  - bonus = 1 when COMBO_BONUS != 0, combo_next != combo, and combo_next mod COMBO_BONUS == 0. Otherwise bonus = 0.
- Miss: combo_next = 0; score is unchanged.
- max_combo_next = max(max_combo, combo_next), updated on the same edge as combo.
- Score arithmetic uses 8-bit internal sums before saturation, so there is no wrap-around.
- Once combo is saturated at 99, further hits give no bonus.

Simultaneous events:
- song_end together with a judgement in PLAY: the judgement is applied and the FSM moves to DONE on the same edge.
- start together with judgements in IDLE or DONE: the counters are cleared and the judgements are ignored.
- reset has priority over every other input in every state, including mid-game.

Display mux:
- disp_sel = 1: amt = {1'b0, combo}.
- disp_sel = 2: amt = {1'b0, max_combo}.
- disp_sel = 0 or 3: amt = {1'b0, score}.
- amt never exceeds 99.

Test Plan:
1. Reset, start, then 3 perfect pulses spaced 2 cycles apart -> score = 6, combo = 3, max_combo = 3, state = 1; amt = 6 with disp_sel = 0.
2. From a fresh game, 9 good pulses then 1 perfect -> the 10th hit awards the bonus: score = 9 + 2 + 1 = 12, combo = 10; amt = 10 with disp_sel = 1.
3. Combo 7, then miss, then 2 good -> combo = 2, max_combo = 7, score up by 2; disp_sel = 2 gives amt = 7.
4. Score 98, then a perfect with combo at 4 -> score = 99 (saturated), combo = 5. Further hits keep score = 99. Drive 120 consecutive good hits -> combo stays at 99.
5. hit_perfect, hit_good and hit_miss asserted in the same cycle with combo = 3 -> only perfect applied: score += 2, combo = 4. song_end in the same cycle as a good hit -> score +1, state = 2, game_over = 1. Later hits are ignored.
6. Mid-game (score 40), assert reset for 1 cycle -> all outputs 0 and state = 0 on the next edge. start while in PLAY -> counters unchanged. start from DONE -> counters cleared and state = 1.
